// File: rtl/hazard_ctrl_multicycle.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_multicycle
//
// Pipeline hazard / flow controller for the 5-stage RV32 core. All pipeline
// register enables and flushes, plus the PC write enable and next-PC select,
// come from here.
//
// Handles:
//   - taken branches in EX and jal in ID (redirect + flush)
//   - multi-cycle load-use / jal-use slips (LOAD_LAT bubbles)
//   - whole-pipe freeze while the data memory has not completed an access
//   - saturating perf counters for stall cycles and redirect events
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_ex_branch/equals   branch in EX and its condition
//   i_id_jump            jal in ID
//   i_id_rs1/rs2         ID source indices, i_use_rs1/rs2 qualify them
//   i_ex_mem_r_en        load in EX
//   i_ex_jump            jal in EX (link value produced late)
//   i_ex_reg_dst         EX destination index
//   i_mem_req/ready      data-memory handshake in MEM
//   o_pc_w_en            PC write enable
//   o_addr_sel           next PC: 00 PC+4, 01 branch target, 10 jump target
//   o_w_en_* / o_flush_* pipeline register enables and flushes
//   o_stall_cycles       cycles spent slipping or frozen (saturating)
//   o_flush_events       branch/jump redirects (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl_multicycle #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32,
    parameter int X0_NO_HAZ  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ex_branch,
    input  logic                  i_ex_equals,
    input  logic                  i_id_jump,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_use_rs1,
    input  logic                  i_use_rs2,
    input  logic                  i_ex_mem_r_en,
    input  logic                  i_ex_jump,
    input  logic [REG_ADDR_W-1:0] i_ex_reg_dst,
    input  logic                  i_mem_req,
    input  logic                  i_mem_ready,
    output logic                  o_pc_w_en,
    output logic [1:0]            o_addr_sel,
    output logic                  o_w_en_if_id,
    output logic                  o_flush_if_id,
    output logic                  o_w_en_id_ex,
    output logic                  o_flush_id_ex,
    output logic                  o_w_en_ex_mem,
    output logic                  o_w_en_mem_wb,
    output logic [CNT_W-1:0]      o_stall_cycles,
    output logic [CNT_W-1:0]      o_flush_events
);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_SLIP    = 2'b01;
    localparam logic [1:0] ST_MEMWAIT = 2'b10;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    // Bubbles still owed after the first one, which is inserted in RUN.
    localparam logic [2:0] SLIP_LOAD  = 3'(LOAD_LAT - 1);
    localparam logic       MULTI_SLIP = (LOAD_LAT > 1);
    localparam logic       X0_SKIP    = (X0_NO_HAZ != 0);

    logic [1:0]       state_q, state_d;
    logic [2:0]       slip_cnt_q, slip_cnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;

    logic taken, haz1, haz2, late, freeze;

    assign taken  = i_ex_branch & i_ex_equals;
    assign haz1   = i_use_rs1 & (i_ex_reg_dst == i_id_rs1) & ~(X0_SKIP & (i_id_rs1 == '0));
    assign haz2   = i_use_rs2 & (i_ex_reg_dst == i_id_rs2) & ~(X0_SKIP & (i_id_rs2 == '0));
    assign late   = (haz1 | haz2) & (i_ex_mem_r_en | i_ex_jump);
    assign freeze = i_mem_req & ~i_mem_ready;

    // JUMP wins over BRANCH here even though a taken branch wins the flush
    // priority; the select is only meaningful when o_pc_w_en is high.
    assign o_addr_sel = i_id_jump ? SEL_JUMP : (taken ? SEL_BRANCH : SEL_PC4);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d       = state_q;
        slip_cnt_d    = slip_cnt_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        o_pc_w_en     = 1'b1;
        o_w_en_if_id  = 1'b1;
        o_flush_if_id = 1'b0;
        o_w_en_id_ex  = 1'b1;
        o_flush_id_ex = 1'b0;
        o_w_en_ex_mem = 1'b1;
        o_w_en_mem_wb = 1'b1;

        if (freeze) begin
            // Whole pipe holds; the pending slip count is kept for later.
            o_pc_w_en     = 1'b0;
            o_w_en_if_id  = 1'b0;
            o_w_en_id_ex  = 1'b0;
            o_w_en_ex_mem = 1'b0;
            o_w_en_mem_wb = 1'b0;
            state_d       = ST_MEMWAIT;
            stall_inc     = 1'b1;
        end else if (taken) begin
            // Both younger instructions are on the wrong path; any slip
            // they were causing is moot.
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
            slip_cnt_d    = '0;
            state_d       = ST_RUN;
            flush_inc     = 1'b1;
        end else if (i_id_jump) begin
            o_flush_if_id = 1'b1;
            state_d       = (slip_cnt_q != '0) ? ST_SLIP : ST_RUN;
            flush_inc     = 1'b1;
        end else if ((state_q == ST_RUN && late) || state_q == ST_SLIP) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            o_pc_w_en     = 1'b0;
            o_w_en_if_id  = 1'b0;
            o_flush_id_ex = 1'b1;
            stall_inc     = 1'b1;
            if (state_q == ST_RUN) begin
                slip_cnt_d = SLIP_LOAD;
                state_d    = MULTI_SLIP ? ST_SLIP : ST_RUN;
            end else begin
                slip_cnt_d = slip_cnt_q - 3'd1;
                if (slip_cnt_q == 3'd1) begin
                    state_d = ST_RUN;
                end
            end
        end else begin
            // Normal flow; also the exit from MEMWAIT, which resumes any
            // slip that the freeze interrupted.
            state_d = (slip_cnt_q != '0) ? ST_SLIP : ST_RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_RUN;
            slip_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            slip_cnt_q <= slip_cnt_d;
            if (stall_inc && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_multicycle.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_multicycle
//
// Two instances share one stimulus stream:
//   dut_a: LOAD_LAT=3, X0_NO_HAZ=1, CNT_W=4
//   dut_b: LOAD_LAT=1, X0_NO_HAZ=0, CNT_W=8
// A driver applies directed then random stimulus, runs a behavioural model
// (pending-bubble count + wait flag) and queues the expected outputs; a
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_multicycle;

    typedef struct packed {
        logic       ex_branch;
        logic       ex_equals;
        logic       id_jump;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic       ex_mem_r_en;
        logic       ex_jump;
        logic [4:0] ex_reg_dst;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    typedef struct packed {
        int bubbles;  // bubbles still owed after the current cycle
        bit in_wait;  // pipe was frozen last cycle
        int stall;
        int flushes;
    } mdl_t;

    typedef struct packed {
        logic       pc_w_en;
        logic [1:0] addr_sel;
        logic       w_en_if_id;
        logic       flush_if_id;
        logic       w_en_id_ex;
        logic       flush_id_ex;
        logic       w_en_ex_mem;
        logic       w_en_mem_wb;
        int         stall;
        int         flushes;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    stim_t s_in = '0;

    always #5 clk = ~clk;

    logic       a_pc_w_en, a_w_en_if_id, a_flush_if_id, a_w_en_id_ex, a_flush_id_ex, a_w_en_ex_mem, a_w_en_mem_wb;
    logic [1:0] a_addr_sel;
    logic [3:0] a_stall, a_flush;
    logic       b_pc_w_en, b_w_en_if_id, b_flush_if_id, b_w_en_id_ex, b_flush_id_ex, b_w_en_ex_mem, b_w_en_mem_wb;
    logic [1:0] b_addr_sel;
    logic [7:0] b_stall, b_flush;

    hazard_ctrl_multicycle #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4), .X0_NO_HAZ(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ex_branch(s_in.ex_branch), .i_ex_equals(s_in.ex_equals), .i_id_jump(s_in.id_jump),
        .i_id_rs1(s_in.id_rs1), .i_id_rs2(s_in.id_rs2), .i_use_rs1(s_in.use_rs1), .i_use_rs2(s_in.use_rs2),
        .i_ex_mem_r_en(s_in.ex_mem_r_en), .i_ex_jump(s_in.ex_jump), .i_ex_reg_dst(s_in.ex_reg_dst),
        .i_mem_req(s_in.mem_req), .i_mem_ready(s_in.mem_ready),
        .o_pc_w_en(a_pc_w_en), .o_addr_sel(a_addr_sel),
        .o_w_en_if_id(a_w_en_if_id), .o_flush_if_id(a_flush_if_id),
        .o_w_en_id_ex(a_w_en_id_ex), .o_flush_id_ex(a_flush_id_ex),
        .o_w_en_ex_mem(a_w_en_ex_mem), .o_w_en_mem_wb(a_w_en_mem_wb),
        .o_stall_cycles(a_stall), .o_flush_events(a_flush)
    );

    hazard_ctrl_multicycle #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(8), .X0_NO_HAZ(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ex_branch(s_in.ex_branch), .i_ex_equals(s_in.ex_equals), .i_id_jump(s_in.id_jump),
        .i_id_rs1(s_in.id_rs1), .i_id_rs2(s_in.id_rs2), .i_use_rs1(s_in.use_rs1), .i_use_rs2(s_in.use_rs2),
        .i_ex_mem_r_en(s_in.ex_mem_r_en), .i_ex_jump(s_in.ex_jump), .i_ex_reg_dst(s_in.ex_reg_dst),
        .i_mem_req(s_in.mem_req), .i_mem_ready(s_in.mem_ready),
        .o_pc_w_en(b_pc_w_en), .o_addr_sel(b_addr_sel),
        .o_w_en_if_id(b_w_en_if_id), .o_flush_if_id(b_flush_if_id),
        .o_w_en_id_ex(b_w_en_id_ex), .o_flush_id_ex(b_flush_id_ex),
        .o_w_en_ex_mem(b_w_en_ex_mem), .o_w_en_mem_wb(b_w_en_mem_wb),
        .o_stall_cycles(b_stall), .o_flush_events(b_flush)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    mdl_t m_a, m_b;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
        end
    endtask

    // Reference behaviour: a freeze holds everything; a redirect wins over a
    // slip; a slip is owed whenever bubbles remain (and no freeze is being
    // left) or a late hazard is seen with nothing pending.
    function automatic void model_step(input stim_t s, input int lat, input bit x0,
                                       input int cmax, inout mdl_t m, output exp_t e);
        bit taken, h1, h2, late, freeze;
        taken  = s.ex_branch && s.ex_equals;
        h1     = s.use_rs1 && (s.ex_reg_dst == s.id_rs1) && !(x0 && s.id_rs1 == 0);
        h2     = s.use_rs2 && (s.ex_reg_dst == s.id_rs2) && !(x0 && s.id_rs2 == 0);
        late   = (h1 || h2) && (s.ex_mem_r_en || s.ex_jump);
        freeze = s.mem_req && !s.mem_ready;

        e.stall       = m.stall;
        e.flushes     = m.flushes;
        e.addr_sel    = s.id_jump ? 2'd2 : (taken ? 2'd1 : 2'd0);
        e.pc_w_en     = 1'b1;
        e.w_en_if_id  = 1'b1;
        e.flush_if_id = 1'b0;
        e.w_en_id_ex  = 1'b1;
        e.flush_id_ex = 1'b0;
        e.w_en_ex_mem = 1'b1;
        e.w_en_mem_wb = 1'b1;

        if (freeze) begin
            e.pc_w_en = 0; e.w_en_if_id = 0; e.w_en_id_ex = 0;
            e.w_en_ex_mem = 0; e.w_en_mem_wb = 0;
            m.in_wait = 1;
            m.stall   = (m.stall < cmax) ? m.stall + 1 : cmax;
        end else if (taken) begin
            e.flush_if_id = 1; e.flush_id_ex = 1;
            m.bubbles = 0;
            m.in_wait = 0;
            m.flushes = (m.flushes < cmax) ? m.flushes + 1 : cmax;
        end else if (s.id_jump) begin
            e.flush_if_id = 1;
            m.in_wait = 0;
            m.flushes = (m.flushes < cmax) ? m.flushes + 1 : cmax;
        end else if (!m.in_wait && (m.bubbles > 0 || late)) begin
            e.pc_w_en = 0; e.w_en_if_id = 0; e.flush_id_ex = 1;
            m.bubbles = (m.bubbles > 0) ? m.bubbles - 1 : lat - 1;
            m.stall   = (m.stall < cmax) ? m.stall + 1 : cmax;
        end else begin
            m.in_wait = 0;
        end
    endfunction

    function automatic stim_t quiet();
        stim_t s = '0;
        s.mem_ready = 1'b1;
        s.ex_reg_dst = 5'd31;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.ex_branch   = ($urandom_range(0, 3) == 0);
        s.ex_equals   = 1'($urandom_range(0, 1));
        s.id_jump     = ($urandom_range(0, 9) == 0);
        s.id_rs1      = 5'($urandom_range(0, 3));
        s.id_rs2      = 5'($urandom_range(0, 3));
        s.use_rs1     = 1'($urandom_range(0, 1));
        s.use_rs2     = 1'($urandom_range(0, 1));
        s.ex_mem_r_en = ($urandom_range(0, 2) == 0);
        s.ex_jump     = ($urandom_range(0, 7) == 0);
        s.ex_reg_dst  = 5'($urandom_range(0, 3));
        s.mem_req     = ($urandom_range(0, 3) == 0);
        // Ready only matters with a request; idle memory reports ready.
        s.mem_ready   = s.mem_req ? ($urandom_range(0, 1) == 0) : 1'b1;
        return s;
    endfunction

    // One clock cycle: change inputs just after the rising edge, compute the
    // expected outputs for this cycle and queue them for the monitor.
    task automatic run_cycle(input stim_t s, input bit do_reset);
        mdl_t tmp;
        exp_t ea, eb;
        @(posedge clk);
        #1;
        cycle++;
        if (do_reset) begin
            rst_n = 1'b0;
            m_a = '0;
            m_b = '0;
        end else begin
            rst_n = 1'b1;
        end
        s_in = s;
        tmp = m_a;
        model_step(s, 3, 1'b1, 15, tmp, ea);
        if (!do_reset) m_a = tmp;
        tmp = m_b;
        model_step(s, 1, 1'b0, 255, tmp, eb);
        if (!do_reset) m_b = tmp;
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic compare(input string tag, input exp_t act, input exp_t exp);
        check({tag, ".pc_w_en"},     int'(act.pc_w_en),     int'(exp.pc_w_en));
        check({tag, ".addr_sel"},    int'(act.addr_sel),    int'(exp.addr_sel));
        check({tag, ".w_en_if_id"},  int'(act.w_en_if_id),  int'(exp.w_en_if_id));
        check({tag, ".flush_if_id"}, int'(act.flush_if_id), int'(exp.flush_if_id));
        check({tag, ".w_en_id_ex"},  int'(act.w_en_id_ex),  int'(exp.w_en_id_ex));
        check({tag, ".flush_id_ex"}, int'(act.flush_id_ex), int'(exp.flush_id_ex));
        check({tag, ".w_en_ex_mem"}, int'(act.w_en_ex_mem), int'(exp.w_en_ex_mem));
        check({tag, ".w_en_mem_wb"}, int'(act.w_en_mem_wb), int'(exp.w_en_mem_wb));
        check({tag, ".stall_cycles"}, act.stall,   exp.stall);
        check({tag, ".flush_events"}, act.flushes, exp.flushes);
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    initial begin
        exp_t act;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                act = '{a_pc_w_en, a_addr_sel, a_w_en_if_id, a_flush_if_id, a_w_en_id_ex,
                        a_flush_id_ex, a_w_en_ex_mem, a_w_en_mem_wb, int'(a_stall), int'(a_flush)};
                compare("a", act, q_a.pop_front());
            end
            if (q_b.size() > 0) begin
                act = '{b_pc_w_en, b_addr_sel, b_w_en_if_id, b_flush_if_id, b_w_en_id_ex,
                        b_flush_id_ex, b_w_en_ex_mem, b_w_en_mem_wb, int'(b_stall), int'(b_flush)};
                compare("b", act, q_b.pop_front());
            end
        end
    end

    initial begin
        stim_t s;
        m_a = '0;
        m_b = '0;

        // Reset state with quiet inputs.
        run_cycle(quiet(), 1'b1);
        run_cycle(quiet(), 1'b1);

        // lw x5 in EX, add reading x5 in ID: a slips 3 cycles, b slips 1.
        s = quiet();
        s.ex_mem_r_en = 1; s.ex_reg_dst = 5'd5; s.id_rs1 = 5'd5; s.use_rs1 = 1;
        run_cycle(s, 1'b0);
        repeat (4) run_cycle(quiet(), 1'b0);

        // lw x0 / rs1=x0: suppressed in a, 1-cycle slip in b.
        s = quiet();
        s.ex_mem_r_en = 1; s.ex_reg_dst = 5'd0; s.id_rs1 = 5'd0; s.use_rs1 = 1;
        run_cycle(s, 1'b0);
        repeat (2) run_cycle(quiet(), 1'b0);

        // Freeze for 4 cycles while a is on its last owed bubble.
        s = quiet();
        s.ex_jump = 1; s.ex_reg_dst = 5'd7; s.id_rs2 = 5'd7; s.use_rs2 = 1;
        run_cycle(s, 1'b0);
        run_cycle(quiet(), 1'b0);
        s = quiet();
        s.mem_req = 1; s.mem_ready = 0;
        repeat (4) run_cycle(s, 1'b0);
        s.mem_ready = 1;
        run_cycle(s, 1'b0);
        repeat (3) run_cycle(quiet(), 1'b0);

        // Taken branch together with a late hazard: redirect, no slip after.
        run_cycle(quiet(), 1'b1);
        s = quiet();
        s.ex_branch = 1; s.ex_equals = 1; s.ex_mem_r_en = 1;
        s.ex_reg_dst = 5'd9; s.id_rs1 = 5'd9; s.use_rs1 = 1;
        run_cycle(s, 1'b0);
        repeat (3) run_cycle(quiet(), 1'b0);

        // Jump in ID with a taken branch: branch flushes win, select says JUMP.
        s = quiet();
        s.id_jump = 1; s.ex_branch = 1; s.ex_equals = 1;
        run_cycle(s, 1'b0);
        s.ex_branch = 0;
        run_cycle(s, 1'b0);

        // Long freeze saturates a's 4-bit stall counter, then async reset
        // while still frozen.
        s = quiet();
        s.mem_req = 1; s.mem_ready = 0;
        repeat (20) run_cycle(s, 1'b0);
        run_cycle(s, 1'b1);
        repeat (3) run_cycle(quiet(), 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            run_cycle(rand_stim(), ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        #1;
        check("queue_drain_a", q_a.size(), 0);
        check("queue_drain_b", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
